// File: rtl/nec_frame_decoder.sv
// ---------------------------------------------------------------------------
// nec_frame_decoder
//
// Takes complete 32-bit NEC frames from the IR receiver and checks the
// inverted address and command bytes. It resolves standard or extended
// addressing, applies an optional address filter, and marks key-hold
// repeats. Accepted frames go into a small FIFO that the command-dispatch
// logic drains through a valid/ready handshake.
//
// Ports
//   clk         system clock
//   rst_n       synchronous active-low reset
//   burst_in    {addr, ~addr, cmd, ~cmd}; [31:24] is the first byte on air
//   burst_rdy   1-cycle strobe, burst_in valid in that cycle
//   out_valid   FIFO head valid
//   out_ready   consumer takes the head when out_valid & out_ready
//   out_addr    16-bit address; standard frames are {8'h00, addr}
//   out_cmd     command byte
//   out_ext     head frame used extended addressing
//   out_repeat  head frame repeats the previous accepted frame inside window
//   err_pulse   1-cycle strobe for a rejected frame
//   err_code    01 cmd mismatch, 10 addr mismatch, 11 filter reject (held)
//   ovf_pulse   1-cycle strobe when a good frame is lost to a full FIFO
//   drop_cnt    saturating count of FIFO-full drops
//   fifo_level  current FIFO occupancy
// ---------------------------------------------------------------------------
module nec_frame_decoder #(
    parameter int          FIFO_DEPTH     = 4,
    parameter int          EXT_ADDR_EN    = 1,
    parameter int          ADDR_FILTER_EN = 0,
    parameter logic [15:0] ADDR_MATCH     = 16'h0000,
    parameter int unsigned REPEAT_CYCLES  = 12_000_000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [31:0]                   burst_in,
    input  logic                          burst_rdy,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [15:0]                   out_addr,
    output logic [7:0]                    out_cmd,
    output logic                          out_ext,
    output logic                          out_repeat,
    output logic                          err_pulse,
    output logic [1:0]                    err_code,
    output logic                          ovf_pulse,
    output logic [7:0]                    drop_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    // Entry layout: {repeat, ext, addr[15:0], cmd[7:0]}
    localparam int ENTRY_W = 26;
    localparam int KEY_W   = 25;

    localparam logic [31:0]      REPEAT_LIMIT = 32'(REPEAT_CYCLES);
    localparam logic [LVL_W-1:0] FULL_LEVEL   = LVL_W'(FIFO_DEPTH);

    // Capture stage
    logic              cap_valid_reg;
    logic [31:0]       cap_data_reg;

    // Frame check
    logic [7:0]        f_addr;
    logic [7:0]        f_addr_inv;
    logic [7:0]        f_cmd;
    logic [7:0]        f_cmd_inv;
    logic              cmd_ok;
    logic              addr_ok;
    logic              f_ext;
    logic [15:0]       f_addr16;
    logic [1:0]        reject_code;
    logic              reject;
    logic              accept;
    logic [KEY_W-1:0]  f_key;
    logic              f_repeat;

    // FIFO
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [LVL_W-1:0]  level_reg;
    logic              fifo_full;
    logic              push;
    logic              pop;
    logic              drop;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] entry_q [FIFO_DEPTH];

    // Status / repeat tracking
    logic              err_pulse_reg;
    logic [1:0]        err_code_reg;
    logic              ovf_pulse_reg;
    logic [7:0]        drop_cnt_reg;
    logic [31:0]       timer_reg;
    logic [KEY_W-1:0]  last_key_reg;

    assign f_addr     = cap_data_reg[31:24];
    assign f_addr_inv = cap_data_reg[23:16];
    assign f_cmd      = cap_data_reg[15:8];
    assign f_cmd_inv  = cap_data_reg[7:0];

    assign cmd_ok  = (f_cmd ^ f_cmd_inv) == 8'hFF;
    assign addr_ok = (f_addr ^ f_addr_inv) == 8'hFF;

    // A broken address inverse is how an extended frame identifies itself;
    // the second byte is then the high byte of a 16-bit address.
    assign f_ext    = (EXT_ADDR_EN != 0) && !addr_ok;
    assign f_addr16 = f_ext ? {f_addr_inv, f_addr} : {8'h00, f_addr};

    always_comb begin
        reject_code = 2'b00;
        if (!cmd_ok) begin
            reject_code = 2'b01;
        end else if (!addr_ok && (EXT_ADDR_EN == 0)) begin
            reject_code = 2'b10;
        end else if ((ADDR_FILTER_EN != 0) && (f_addr16 != ADDR_MATCH)) begin
            reject_code = 2'b11;
        end
    end

    assign reject = cap_valid_reg && (reject_code != 2'b00);
    assign accept = cap_valid_reg && (reject_code == 2'b00);

    // The timer stays saturated after reset, so the first frame never
    // reports a repeat regardless of what last_key_reg holds.
    assign f_key    = {f_addr16, f_cmd, f_ext};
    assign f_repeat = (f_key == last_key_reg) && (timer_reg < REPEAT_LIMIT);

    assign fifo_full  = (level_reg == FULL_LEVEL);
    assign pop        = (level_reg != '0) && out_ready;
    // A full FIFO still takes a frame when the head leaves in the same cycle.
    assign push       = accept && (!fifo_full || pop);
    assign drop       = accept && fifo_full && !pop;
    assign push_entry = {f_repeat, f_ext, f_addr16, f_cmd};

    // FIFO storage: one register per entry, written only when the write
    // pointer selects it, so the head entry is never disturbed while waiting.
    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            logic [ENTRY_W-1:0] data_reg;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    data_reg <= '0;
                end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    data_reg <= push_entry;
                end
            end

            assign entry_q[gi] = data_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cap_valid_reg <= 1'b0;
            cap_data_reg  <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            level_reg     <= '0;
            err_pulse_reg <= 1'b0;
            err_code_reg  <= 2'b00;
            ovf_pulse_reg <= 1'b0;
            drop_cnt_reg  <= '0;
            timer_reg     <= REPEAT_LIMIT;
            last_key_reg  <= '0;
        end else begin
            // A new strobe simply overwrites whatever is being checked now;
            // the previous capture has already been consumed this cycle.
            cap_valid_reg <= burst_rdy;
            if (burst_rdy) begin
                cap_data_reg <= burst_in;
            end

            err_pulse_reg <= reject;
            if (reject) begin
                err_code_reg <= reject_code;
            end

            ovf_pulse_reg <= drop;
            if (drop && (drop_cnt_reg != 8'hFF)) begin
                drop_cnt_reg <= drop_cnt_reg + 8'd1;
            end

            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end

            case ({push, pop})
                2'b10:   level_reg <= level_reg + LVL_W'(1);
                2'b01:   level_reg <= level_reg - LVL_W'(1);
                default: level_reg <= level_reg;
            endcase

            // Dropped frames still count as accepted for repeat detection:
            // the key was really pressed even if the consumer fell behind.
            if (accept) begin
                timer_reg    <= '0;
                last_key_reg <= f_key;
            end else if (timer_reg < REPEAT_LIMIT) begin
                timer_reg <= timer_reg + 32'd1;
            end
        end
    end

    assign out_valid  = (level_reg != '0);
    assign out_cmd    = entry_q[rd_ptr_reg][7:0];
    assign out_addr   = entry_q[rd_ptr_reg][23:8];
    assign out_ext    = entry_q[rd_ptr_reg][24];
    assign out_repeat = entry_q[rd_ptr_reg][25];
    assign err_pulse  = err_pulse_reg;
    assign err_code   = err_code_reg;
    assign ovf_pulse  = ovf_pulse_reg;
    assign drop_cnt   = drop_cnt_reg;
    assign fifo_level = level_reg;

endmodule
